// File: rtl/vita49_timed_gate.sv
// Timed burst gate: forwards burst_len AXI-stream beats starting at the sample whose
// VITA49 timestamp {tsi,tsf} equals the armed target; all other beats are discarded.
//
// state | meaning
// IDLE  | no burst pending, input discarded
// ARMED | target latched, waiting for now == target
// RUN   | forwarding beats into the output skid buffer
// DRAIN | final beat queued, waiting for it to leave m_axis
module vita49_timed_gate #(
    parameter int DATA_W = 32
) (
    input  logic              samp_clk,
    input  logic              ARESETN,
    input  logic              arm,
    input  logic              abort,
    input  logic [31:0]       trig_tsi,
    input  logic [63:0]       trig_tsf,
    input  logic [31:0]       burst_len,
    input  logic [31:0]       tsi,
    input  logic [63:0]       tsf,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [1:0]        state,
    output logic              late,
    output logic              underrun,
    output logic              bad_arm,
    output logic              done,
    output logic [31:0]       beat_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             st;
    logic [95:0]        tgt_q;
    logic [31:0]        len_q;
    logic               abort_pend;
    logic [DATA_W-1:0]  skid_data;
    logic               skid_valid;
    logic               skid_last;

    logic [95:0] now_ts;
    logic        arm_ok;
    logic        match;
    logic        past;
    logic        run_cycle;
    logic        take;
    logic        close;
    logic        last_out;
    logic        do_latch;

    assign now_ts   = {tsi, tsf};
    assign arm_ok   = arm && (burst_len != 32'd0);
    assign match    = (now_ts == tgt_q);
    assign past     = (now_ts > tgt_q);

    // The match cycle in ARMED already behaves as the first RUN cycle.
    assign run_cycle = (st == RUN) || ((st == ARMED) && !abort && !arm_ok && match);
    assign take      = run_cycle && s_axis_tvalid && !skid_valid;

    // A beat accepted in the abort cycle itself closes the burst.
    assign close     = take && (((beat_cnt + 32'd1) == len_q) || abort_pend ||
                                ((st == RUN) && abort));
    assign last_out  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign do_latch  = arm_ok && ((st == IDLE) || ((st == ARMED) && !abort) ||
                                  ((st == DRAIN) && last_out));

    assign s_axis_tready = run_cycle ? !skid_valid : 1'b1;
    assign state         = st;

    always_ff @(posedge samp_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            st         <= IDLE;
            tgt_q      <= '0;
            len_q      <= '0;
            abort_pend <= 1'b0;
            late       <= 1'b0;
            underrun   <= 1'b0;
            bad_arm    <= 1'b0;
            done       <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (arm && (burst_len == 32'd0) && ((st == IDLE) || (st == ARMED)))
                bad_arm <= 1'b1;
            if (run_cycle && !s_axis_tvalid)
                underrun <= 1'b1;
            if (take)
                beat_cnt <= beat_cnt + 32'd1;

            case (st)
                IDLE: begin
                    if (arm_ok)
                        st <= ARMED;
                end
                ARMED: begin
                    if (abort) begin
                        st <= IDLE;
                    end else if (arm_ok) begin
                        st <= ARMED;
                    end else if (match) begin
                        st <= close ? DRAIN : RUN;
                    end else if (past) begin
                        late <= 1'b1;
                        st   <= IDLE;
                    end
                end
                RUN: begin
                    if (close) begin
                        st         <= DRAIN;
                        abort_pend <= 1'b0;
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_out) begin
                        done <= 1'b1;
                        st   <= arm_ok ? ARMED : IDLE;
                    end
                end
                default: st <= IDLE;
            endcase

            if (do_latch) begin
                tgt_q      <= {trig_tsi, trig_tsf};
                len_q      <= burst_len;
                beat_cnt   <= '0;
                late       <= 1'b0;
                underrun   <= 1'b0;
                abort_pend <= 1'b0;
            end
        end
    end

    // Two-entry buffer: the m_axis register is the head, skid holds a second beat.
    always_ff @(posedge samp_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            skid_data     <= '0;
            skid_valid    <= 1'b0;
            skid_last     <= 1'b0;
        end else if (!m_axis_tvalid || m_axis_tready) begin
            if (skid_valid) begin
                m_axis_tdata  <= skid_data;
                m_axis_tlast  <= skid_last;
                m_axis_tvalid <= 1'b1;
                skid_valid    <= 1'b0;
            end else if (take) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= close;
                m_axis_tvalid <= 1'b1;
            end else begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end else if (take) begin
            skid_data  <= s_axis_tdata;
            skid_last  <= close;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vita49_timed_gate.sv
// Bench for vita49_timed_gate: queue-based behavioural model checked every cycle,
// plus literal expectations on the beats delivered by each directed burst.
module tb_vita49_timed_gate;

    logic        samp_clk = 1'b0;
    logic        ARESETN  = 1'b1;
    logic        arm = 1'b0, abort = 1'b0;
    logic [31:0] trig_tsi = '0;
    logic [63:0] trig_tsf = '0;
    logic [31:0] burst_len = '0;
    logic [31:0] tsi = '0;
    logic [63:0] tsf = '0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b1;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic [1:0]  state;
    logic        late, underrun, bad_arm, done;
    logic [31:0] beat_cnt;

    vita49_timed_gate #(.DATA_W(32)) dut (
        .samp_clk(samp_clk), .ARESETN(ARESETN), .arm(arm), .abort(abort),
        .trig_tsi(trig_tsi), .trig_tsf(trig_tsf), .burst_len(burst_len),
        .tsi(tsi), .tsf(tsf),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(m_last), .state(state), .late(late), .underrun(underrun),
        .bad_arm(bad_arm), .done(done), .beat_cnt(beat_cnt)
    );

    always #5 samp_clk = ~samp_clk;

    typedef struct packed { logic last; logic [31:0] data; } beat_t;

    int nvec = 0, nerr = 0;
    int ndone = 0;
    bit ramp = 1'b1, tog = 1'b0;
    beat_t got[$];

    // model state
    int          m_ph = 0;
    logic [95:0] m_tgt = '0;
    logic [31:0] m_len = '0, m_cnt = '0;
    bit          m_late = 0, m_under = 0, m_bad = 0, m_done = 0, m_abt = 0;
    beat_t       mq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_run_now();
        return (m_ph == 2) ||
               (m_ph == 1 && !abort && !(arm && burst_len != 0) && {tsi, tsf} == m_tgt);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_tgt = '0; m_len = '0; m_cnt = '0;
        m_late = 0; m_under = 0; m_bad = 0; m_done = 0; m_abt = 0;
        mq.delete();
    endtask

    task automatic model_latch();
        m_tgt = {trig_tsi, trig_tsf}; m_len = burst_len; m_cnt = '0;
        m_late = 0; m_under = 0; m_abt = 0; m_ph = 1;
    endtask

    task automatic model_step();
        logic [95:0] now;
        bit run, take, lastb, popped_last, arm_ok, abt;
        beat_t b;
        now    = {tsi, tsf};
        arm_ok = arm && burst_len != 0;
        run    = m_run_now();
        take   = run && s_valid && mq.size() < 2;
        popped_last = 0;
        if (mq.size() > 0 && m_ready) begin
            popped_last = mq[0].last;
            void'(mq.pop_front());
        end
        m_done = 0;
        if (arm && burst_len == 0 && (m_ph == 0 || m_ph == 1)) m_bad = 1;
        if (run) begin
            if (!s_valid) m_under = 1;
            abt = m_abt || (m_ph == 2 && abort);
            if (take) begin
                m_cnt = m_cnt + 1;
                lastb = (m_cnt == m_len) || abt;
                b.last = lastb; b.data = s_data;
                mq.push_back(b);
                m_ph  = lastb ? 3 : 2;
                m_abt = lastb ? 1'b0 : abt;
            end else begin
                m_ph  = 2;
                m_abt = abt;
            end
        end else begin
            case (m_ph)
                0: if (arm_ok) model_latch();
                1: if (abort) m_ph = 0;
                   else if (arm_ok) model_latch();
                   else if (now > m_tgt) begin m_late = 1; m_ph = 0; end
                3: if (popped_last) begin
                       m_done = 1; m_ph = 0;
                       if (arm_ok) model_latch();
                   end
                default: ;
            endcase
        end
    endtask

    always @(posedge samp_clk or negedge ARESETN) begin
        if (!ARESETN) model_reset();
        else model_step();
    end

    always @(negedge samp_clk) begin
        chk("state", 64'(state), 64'(m_ph));
        chk("m_tvalid", 64'(m_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("m_tdata", 64'(m_data), 64'(mq[0].data));
            chk("m_tlast", 64'(m_last), 64'(mq[0].last));
        end
        chk("late", 64'(late), 64'(m_late));
        chk("underrun", 64'(underrun), 64'(m_under));
        chk("bad_arm", 64'(bad_arm), 64'(m_bad));
        chk("done", 64'(done), 64'(m_done));
        chk("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
        chk("s_tready", 64'(s_ready), 64'(m_run_now() ? (mq.size() < 2) : 1'b1));
        if (m_valid && m_ready) begin
            beat_t b;
            b.last = m_last; b.data = m_data;
            got.push_back(b);
        end
        if (done) ndone++;
    end

    // Source advances to the next sample only after a handshake.
    task automatic cyc();
        bit hs;
        @(negedge samp_clk);
        hs = s_valid && s_ready;
        @(posedge samp_clk);
        #1;
        arm = 0; abort = 0;
        if (ramp) tsf = tsf + 1;
        if (hs) s_data = s_data + 1;
        if (tog) m_ready = ~m_ready;
    endtask

    task automatic set_ts(input logic [31:0] si, input logic [63:0] sf);
        tsi = si; tsf = sf; s_data = sf[31:0];
    endtask

    task automatic do_arm(input logic [31:0] si, input logic [63:0] sf, input logic [31:0] len);
        trig_tsi = si; trig_tsf = sf; burst_len = len; arm = 1;
    endtask

    task automatic check_burst(input string nm, input int n, input int first);
        chk({nm, "_nbeats"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < got.size() && i < n; i++) begin
            chk({nm, "_data"}, 64'(got[i].data), 64'(first + i));
            chk({nm, "_last"}, 64'(got[i].last), 64'(i == n - 1));
        end
        chk({nm, "_ndone"}, 64'(ndone), 64'd1);
        chk({nm, "_beat_cnt"}, 64'(beat_cnt), 64'(n));
        chk({nm, "_idle"}, 64'(state), 64'd0);
    endtask

    task automatic start_test();
        got.delete(); ndone = 0;
        set_ts(32'd5, 64'd90);
        s_valid = 1; m_ready = 1; tog = 0; ramp = 1;
        cyc(); cyc();
    endtask

    initial begin
        #1 ARESETN = 0;
        #2;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_tvalid", 64'(m_valid), 64'd0);
        chk("rst_tlast", 64'(m_last), 64'd0);
        chk("rst_tdata", 64'(m_data), 64'd0);
        chk("rst_flags", 64'({late, underrun, bad_arm, done}), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        cyc(); cyc();
        ARESETN = 1;
        cyc();

        // T1: basic burst of 4 at (5,100)
        start_test();
        do_arm(32'd5, 64'd100, 32'd4);
        repeat (20) cyc();
        check_burst("t1", 4, 100);

        // T2: output back-pressure toggling
        start_test();
        tog = 1;
        do_arm(32'd5, 64'd100, 32'd4);
        repeat (24) cyc();
        tog = 0; m_ready = 1;
        cyc();
        check_burst("t2", 4, 100);

        // T3: target already passed when armed
        got.delete(); ndone = 0;
        set_ts(32'd5, 64'd200);
        do_arm(32'd5, 64'd100, 32'd4);
        cyc(); cyc();
        chk("t3_late", 64'(late), 64'd1);
        chk("t3_state", 64'(state), 64'd0);
        repeat (4) cyc();
        chk("t3_nbeats", 64'(got.size()), 64'd0);

        // T4: abort in the cycle offering the 4th beat of a 10-beat burst
        start_test();
        do_arm(32'd5, 64'd100, 32'd10);
        repeat (11) cyc();
        chk("t4_tsf", tsf, 64'd103);
        abort = 1;
        repeat (15) cyc();
        check_burst("t4", 4, 100);

        // T7: input gap inside the burst raises underrun, burst continues
        start_test();
        do_arm(32'd5, 64'd100, 32'd3);
        repeat (9) cyc();
        s_valid = 0;
        cyc();
        s_valid = 1;
        repeat (12) cyc();
        check_burst("t7", 3, 100);
        chk("t7_underrun", 64'(underrun), 64'd1);

        // T5: zero-length arm, then seconds jump past the target while armed
        got.delete(); ndone = 0;
        do_arm(32'd5, 64'd100, 32'd0);
        cyc(); cyc();
        chk("t5_bad_arm", 64'(bad_arm), 64'd1);
        chk("t5_idle", 64'(state), 64'd0);
        set_ts(32'd5, 64'd0);
        do_arm(32'd7, 64'd0, 32'd4);
        repeat (3) cyc();
        chk("t5_armed", 64'(state), 64'd1);
        tsi = 32'd8;
        cyc(); cyc();
        chk("t5_late", 64'(late), 64'd1);
        chk("t5_state", 64'(state), 64'd0);
        chk("t5_nbeats", 64'(got.size()), 64'd0);

        // T6: async reset with two beats held in the buffer
        start_test();
        m_ready = 0;
        do_arm(32'd5, 64'd100, 32'd10);
        repeat (11) cyc();
        chk("t6_pre_valid", 64'(m_valid), 64'd1);
        chk("t6_pre_cnt", 64'(beat_cnt), 64'd2);
        #2 ARESETN = 0;
        #1;
        chk("t6_state", 64'(state), 64'd0);
        chk("t6_tvalid", 64'(m_valid), 64'd0);
        chk("t6_tlast", 64'(m_last), 64'd0);
        chk("t6_tdata", 64'(m_data), 64'd0);
        chk("t6_flags", 64'({late, underrun, bad_arm, done}), 64'd0);
        chk("t6_beat_cnt", 64'(beat_cnt), 64'd0);
        cyc();
        ARESETN = 1; m_ready = 1;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
